// File: rtl/wallace_mult_pipe_if.sv
// Operand/result handshake bundle for wallace_mult_pipe (valid/ready on both sides).
// The master drives operands and out_ready; the slave (multiplier) drives in_ready, out_valid and result.
interface wallace_mult_pipe_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/wallace_mult_pipe.sv
// Pipelined Baugh-Wooley / carry-save-tree multiplier; optional running accumulator via WALLACE_MULT_ACC_EN.
// Latency STAGES cycles, one pair per cycle; a stalled output freezes every stage and drops in_ready.
module wallace_mult_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef WALLACE_MULT_ACC_EN
  input  logic                 acc_clear,
  output logic [2*WIDTH+7:0]   acc,
`endif
  wallace_mult_pipe_if.slave   bus
);

  localparam int PW = 2 * WIDTH;
  localparam int NR = WIDTH + 1;  // WIDTH partial products plus the Baugh-Wooley constant row

  typedef logic [NR-1:0][PW-1:0] rows_t;

  function automatic int next_rows(int n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int count_levels(int n);
    int l;
    int m;
    l = 0;
    m = n;
    while (m > 2) begin
      m = next_rows(m);
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = count_levels(NR);
  localparam int LPS    = (LEVELS + STAGES - 1) / STAGES;
  localparam int PS     = (STAGES > 1) ? STAGES - 1 : 1;

  // One 3:2 level: each full triple becomes sum/carry rows, leftovers pass through, the rest is zeroed.
  function automatic rows_t csa_level(rows_t r, int n);
    rows_t o;
    o = '0;
    for (int g = 0; g < NR / 3; g++) begin
      if (g < n / 3) begin
        o[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
        o[2*g+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) | (r[3*g+1] & r[3*g+2])) << 1;
      end
    end
    for (int j = 0; j < NR; j++) begin
      if (j >= 3 * (n / 3) && j < n) o[j - n / 3] = r[j];
    end
    return o;
  endfunction

  function automatic rows_t reduce(rows_t r, int first);
    rows_t o;
    int    n;
    o = r;
    n = NR;
    for (int l = 0; l < LEVELS; l++) begin
      if (l >= first && l < first + LPS) o = csa_level(o, n);
      n = next_rows(n);
    end
    return o;
  endfunction

  function automatic rows_t gen_pp(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic sm);
    rows_t r;
    logic  p;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        p = x[j] & y[i];
        if (sm && ((i == WIDTH - 1) != (j == WIDTH - 1))) p = ~p;
        r[i][i+j] = p;
      end
    end
    if (sm) begin
      r[WIDTH][WIDTH]  = 1'b1;
      r[WIDTH][PW-1]   = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] sum_rows(rows_t r);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < NR; i++) s = s + r[i];
    return s;
  endfunction

  logic              advance;
  logic [STAGES-1:0] vld_q, vld_d;
  rows_t             pp_rows;
  rows_t             rows_q [PS];
  rows_t             rows_d [PS];
  logic [PW-1:0]     result_q, result_d;

  always_comb begin
    advance  = !vld_q[STAGES-1] || bus.out_ready;
    pp_rows  = gen_pp(bus.a, bus.b, bus.signed_mode);
    vld_d    = vld_q;
    rows_d   = rows_q;
    result_d = result_q;
    if (advance) begin
      vld_d     = (vld_q << 1) | STAGES'(bus.in_valid);
      rows_d[0] = reduce(pp_rows, 0);
      for (int s = 1; s < PS; s++) rows_d[s] = reduce(rows_q[s-1], s * LPS);
      result_d  = sum_rows(reduce((STAGES == 1) ? pp_rows : rows_q[PS-1], (STAGES - 1) * LPS));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      rows_q   <= '{default: '0};
      result_q <= '0;
    end else begin
      vld_q    <= vld_d;
      rows_q   <= rows_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.result    = result_q;

`ifdef WALLACE_MULT_ACC_EN
  logic [STAGES-1:0] sm_q, sm_d;
  logic [PW+7:0]     acc_q, acc_d, acc_ext;
  logic              out_hs;

  // The mode bit rides alongside each product so the accumulator knows how to extend it.
  always_comb begin
    sm_d    = advance ? ((sm_q << 1) | STAGES'(bus.signed_mode)) : sm_q;
    out_hs  = vld_q[STAGES-1] && bus.out_ready;
    acc_ext = sm_q[STAGES-1] ? {{8{result_q[PW-1]}}, result_q} : {8'b0, result_q};
    acc_d   = acc_q;
    if (acc_clear)   acc_d = out_hs ? acc_ext : '0;
    else if (out_hs) acc_d = acc_q + acc_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sm_q  <= '0;
      acc_q <= '0;
    end else begin
      sm_q  <= sm_d;
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;
`endif

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Directed-vector bench for wallace_mult_pipe at WIDTH=8, STAGES=3.
// Accumulator scenarios are exercised when WALLACE_MULT_ACC_EN is defined.
module tb_wallace_mult_pipe;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wallace_mult_pipe_if #(.WIDTH(W)) bus ();

`ifdef WALLACE_MULT_ACC_EN
  logic              acc_clear;
  logic [2*W+7:0]    acc;
`endif

  wallace_mult_pipe #(.WIDTH(W), .STAGES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef WALLACE_MULT_ACC_EN
    .acc_clear (acc_clear),
    .acc       (acc),
`endif
    .bus       (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y, input logic sm);
    bus.in_valid    = v;
    bus.a           = x;
    bus.b           = y;
    bus.signed_mode = sm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    bus.out_ready = 1'b1;
`ifdef WALLACE_MULT_ACC_EN
    acc_clear = 1'b0;
`endif
    step();
    step();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_vec++;
    if (bus.result !== 16'h0000) begin n_bad++; $display("FAIL reset_result: got %h expected 0000", bus.result); end
    rst_n = 1'b1;
    step();
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    bus.out_ready = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_in_ready_no_out_ready: got %b expected 1", bus.in_ready); end
    bus.out_ready = 1'b1;
`ifdef WALLACE_MULT_ACC_EN
    n_vec++;
    if (acc !== 24'd0) begin n_bad++; $display("FAIL reset_acc: got %0d expected 0", acc); end
`endif
  endtask

  task automatic test_latency();
    int lat;
    drive(1'b1, 8'd255, 8'd255, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    n_vec++;
    if (lat != 3) begin n_bad++; $display("FAIL latency: got %0d cycles expected 3", lat); end
    n_vec++;
    if (bus.result !== 16'hFE01) begin n_bad++; $display("FAIL u255x255: got %h expected fe01", bus.result); end
    step();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bubble_after_single: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_modes();
    logic [7:0]  ta [9];
    logic [7:0]  tb [9];
    logic        ts [9];
    logic [15:0] te [9];
    int got;
    ta = '{8'h80, 8'hFF, 8'h80, 8'hFF, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h7F};
    tb = '{8'h80, 8'h01, 8'h80, 8'h01, 8'h80, 8'hFF, 8'hAB, 8'h80, 8'h7F};
    ts = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
    te = '{16'h4000, 16'hFFFF, 16'h4000, 16'h00FF, 16'hC080, 16'h0001, 16'h0000, 16'h0000, 16'h3F01};
    got = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 9) drive(1'b1, ta[c], tb[c], ts[c]);
      else       drive(1'b0, 8'h00, 8'h00, 1'b0);
      step();
      if (bus.out_valid === 1'b1) begin
        n_vec++;
        if (got >= 9) begin
          n_bad++; $display("FAIL modes_extra_output: got %h expected none", bus.result);
        end else if (bus.result !== te[got]) begin
          n_bad++; $display("FAIL modes_vec%0d: got %h expected %h", got, bus.result, te[got]);
        end
        got++;
      end
    end
    n_vec++;
    if (got != 9) begin n_bad++; $display("FAIL modes_count: got %0d expected 9", got); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  sa [4];
    logic [7:0]  sb [4];
    logic [15:0] se [4];
    int got;
    int first;
    sa = '{8'd1, 8'd2, 8'd4, 8'd6};
    sb = '{8'd1, 8'd3, 8'd5, 8'd7};
    se = '{16'd1, 16'd6, 16'd20, 16'd42};
    got = 0;
    first = -1;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) drive(1'b1, sa[c], sb[c], 1'b0);
      else       drive(1'b0, 8'h00, 8'h00, 1'b0);
      step();
      if (bus.out_valid === 1'b1) begin
        if (first < 0) first = c;
        n_vec++;
        if (got >= 4) begin
          n_bad++; $display("FAIL stream_extra_output: got %h expected none", bus.result);
        end else if (bus.result !== se[got] || c != first + got) begin
          n_bad++; $display("FAIL stream_vec%0d: got %0d at cycle %0d expected %0d at cycle %0d",
                            got, bus.result, c, se[got], first + got);
        end
        got++;
      end
    end
    n_vec++;
    if (got != 4) begin n_bad++; $display("FAIL stream_count: got %0d expected 4", got); end
    n_vec++;
    if (first != 2) begin n_bad++; $display("FAIL stream_first_cycle: got %0d expected 2", first); end
  endtask

  task automatic test_stall();
    logic [7:0]  va [3];
    logic [7:0]  vb [3];
    logic [15:0] ve [3];
    int got;
    va = '{8'd3, 8'd5, 8'd7};
    vb = '{8'd4, 8'd6, 8'd8};
    ve = '{16'd12, 16'd30, 16'd56};
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, va[c], vb[c], 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready c%0d: got %b expected 0", c, bus.in_ready); end
      n_vec++;
      if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_out_valid c%0d: got %b expected 1", c, bus.out_valid); end
      n_vec++;
      if (bus.result !== 16'd12) begin n_bad++; $display("FAIL stall_result c%0d: got %0d expected 12", c, bus.result); end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
    got = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid === 1'b1) begin
        n_vec++;
        if (got >= 3) begin
          n_bad++; $display("FAIL drain_extra_output: got %0d expected none", bus.result);
        end else if (bus.result !== ve[got]) begin
          n_bad++; $display("FAIL drain_vec%0d: got %0d expected %0d", got, bus.result, ve[got]);
        end
        got++;
      end
      step();
    end
    n_vec++;
    if (got != 3) begin n_bad++; $display("FAIL drain_count: got %0d expected 3", got); end
  endtask

  task automatic test_reset_mid();
    int spurious;
    int lat;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'd9, 8'd9, 1'b0); step();
    drive(1'b1, 8'd8, 8'd8, 1'b0); step();
    drive(1'b1, 8'd7, 8'd7, 1'b0); step();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid: got %b expected 0", bus.out_valid); end
    n_vec++;
    if (bus.result !== 16'h0000) begin n_bad++; $display("FAIL midreset_result: got %h expected 0000", bus.result); end
    step();
    rst_n = 1'b1;
    spurious = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.out_valid !== 1'b0) spurious++;
    end
    n_vec++;
    if (spurious != 0) begin n_bad++; $display("FAIL midreset_spurious: got %0d valid cycles expected 0", spurious); end
    drive(1'b1, 8'd2, 8'd2, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    n_vec++;
    if (lat != 3 || bus.result !== 16'd4) begin
      n_bad++; $display("FAIL postreset_product: got %0d after %0d cycles expected 4 after 3", bus.result, lat);
    end
    step();
  endtask

`ifdef WALLACE_MULT_ACC_EN
  task automatic test_acc();
    logic [7:0]     xa [3];
    logic [7:0]     xb [3];
    logic           xs [3];
    logic [23:0]    xe [3];
    int seen;
    logic pend;
    int lat;
    xa = '{8'd10, 8'hFF, 8'd3};
    xb = '{8'd10, 8'h02, 8'd3};
    xs = '{1'b0,  1'b1,  1'b0};
    xe = '{24'd100, 24'd98, 24'd107};
    acc_clear = 1'b1;
    step();
    acc_clear = 1'b0;
    n_vec++;
    if (acc !== 24'd0) begin n_bad++; $display("FAIL acc_clear_idle: got %0d expected 0", acc); end
    seen = 0;
    pend = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) drive(1'b1, xa[c], xb[c], xs[c]);
      else       drive(1'b0, 8'h00, 8'h00, 1'b0);
      step();
      if (pend) begin
        n_vec++;
        if (acc !== xe[seen-1]) begin n_bad++; $display("FAIL acc_step%0d: got %0d expected %0d", seen - 1, acc, xe[seen-1]); end
      end
      pend = (bus.out_valid === 1'b1) && (seen < 3);
      if (pend) seen++;
    end
    n_vec++;
    if (seen != 3) begin n_bad++; $display("FAIL acc_outputs: got %0d expected 3", seen); end
    drive(1'b1, 8'd3, 8'd3, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    acc_clear = 1'b1;
    step();
    acc_clear = 1'b0;
    n_vec++;
    if (acc !== 24'd9) begin n_bad++; $display("FAIL acc_clear_with_product: got %0d expected 9", acc); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef WALLACE_MULT_ACC_EN
    test_acc();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
